// File: rtl/wb_write_stage.sv
// ============================================================================
// wb_write_stage -- MEM/WB pipeline stage with a 2-entry skid buffer
//
// Purpose:
//   Captures one memory-stage result per upstream transfer. The write data is
//   chosen between the load data and the ALU result when the entry is
//   captured. The stage then presents the entry to the register-file write
//   port. A head entry and a skid entry let the regfile stall (wb_ready=0)
//   without any instruction being lost. Entries leave in arrival order.
//
// Optional feature (macro WB_RETIRE_COUNT_EN):
//   When the macro is defined, retire_count is a 32-bit wrapping count of
//   downstream transfers. Only reset clears it; flush does not.
//   When the macro is undefined, retire_count is tied to zero and the design
//   contains no counter flops.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   in_valid       in   upstream entry valid
//   in_ready       out  stage can accept an entry (registered, = !skid_valid)
//   in_regwrite    in   entry writes a register
//   in_mem_to_reg  in   1 = load data, 0 = ALU result
//   in_rd          in   destination register index
//   in_alu_result  in   ALU result
//   in_mem_data    in   load data
//   flush          in   discard all held entries
//   wb_ready       in   regfile accepts a write this cycle
//   wb_valid       out  head entry presented
//   wb_en          out  regfile write enable (suppressed for X31)
//   wb_addr        out  write address (head rd)
//   wb_data        out  write data (head data)
//   retire_count   out  retired-entry counter
// ============================================================================
module wb_write_stage #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_mem_to_reg,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic              flush,
    input  logic              wb_ready,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       retire_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_in_ready;
    logic              r_head_regwrite;
    logic [ADDR_W-1:0] r_head_rd;
    logic [DATA_W-1:0] r_head_data;
    logic              r_skid_regwrite;
    logic [ADDR_W-1:0] r_skid_rd;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_accept;
    logic              w_deq;
    logic              w_load_head_in;
    logic              w_load_skid;
    logic              w_head_from_skid;
    logic [DATA_W-1:0] w_in_data;

    // A transfer that coincides with flush is dropped, so it never counts as
    // an accept.
    assign w_accept  = in_valid & r_in_ready & ~flush;
    assign w_deq     = wb_valid & wb_ready;
    assign w_in_data = in_mem_to_reg ? in_mem_data : in_alu_result;

    // Next-state and data-movement decode
    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = ST_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deq) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next = ST_FULL;
                    w_load_skid  = 1'b1;
                end else if (w_deq) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_deq) begin
                    w_state_next     = ST_ONE;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // Flush wins over all movement. The head fields keep their last value,
        // so wb_addr and wb_data stay stable while the stage is empty.
        if (flush) begin
            w_state_next     = ST_EMPTY;
            w_load_head_in   = 1'b0;
            w_load_skid      = 1'b0;
            w_head_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_EMPTY;
            r_in_ready      <= 1'b1;
            r_head_regwrite <= 1'b0;
            r_head_rd       <= '0;
            r_head_data     <= '0;
            r_skid_regwrite <= 1'b0;
            r_skid_rd       <= '0;
            r_skid_data     <= '0;
        end else begin
            r_state    <= w_state_next;
            // in_ready is registered: it is high in every cycle in which the
            // skid slot is empty.
            r_in_ready <= (w_state_next != ST_FULL);
            if (w_load_head_in) begin
                r_head_regwrite <= in_regwrite;
                r_head_rd       <= in_rd;
                r_head_data     <= w_in_data;
            end else if (w_head_from_skid) begin
                r_head_regwrite <= r_skid_regwrite;
                r_head_rd       <= r_skid_rd;
                r_head_data     <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_regwrite <= in_regwrite;
                r_skid_rd       <= in_rd;
                r_skid_data     <= w_in_data;
            end
        end
    end

    assign in_ready = r_in_ready;
    assign wb_valid = (r_state != ST_EMPTY);
    // The all-ones index is the hard-wired zero register. Such a write is
    // presented and retires, but it never asserts the write enable.
    assign wb_en    = wb_valid & r_head_regwrite & ~(&r_head_rd);
    assign wb_addr  = r_head_rd;
    assign wb_data  = r_head_data;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] r_retire_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (w_deq) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;
`else
    assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_stage.sv
// Scoreboard bench for wb_write_stage. When an upstream transfer is issued,
// the stimulus pushes the expected write. A monitor pops that write and
// compares it on every downstream transfer.
module tb_wb_write_stage;
    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_regwrite;
    logic          in_mem_to_reg;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_alu_result;
    logic [DW-1:0] in_mem_data;
    logic          flush;
    logic          wb_ready;
    logic          wb_valid;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [31:0]   retire_count;

    wb_write_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_regwrite  (in_regwrite),
        .in_mem_to_reg(in_mem_to_reg),
        .in_rd        (in_rd),
        .in_alu_result(in_alu_result),
        .in_mem_data  (in_mem_data),
        .flush        (flush),
        .wb_ready     (wb_ready),
        .wb_valid     (wb_valid),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic          en;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic [31:0] exp_retire = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream beat for one cycle. The expected write is queued only
    // if the stage takes the beat.
    task automatic send(input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem, input logic m2r, input logic rw,
                        input logic fl);
        exp_t e;
        in_valid      = 1'b1;
        in_rd         = rd;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_mem_to_reg = m2r;
        in_regwrite   = rw;
        flush         = fl;
        if (in_ready && !fl && !reset) begin
            e.rd   = rd;
            e.data = m2r ? mem : alu;
            e.en   = rw && (rd != 5'd31);
            sb.push_back(e);
        end
        $display("send rd=%0d alu=0x%0h mem=0x%0h m2r=%0b rw=%0b flush=%0b", rd, alu, mem, m2r, rw, fl);
        cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_retire(input string name);
`ifdef WB_RETIRE_COUNT_EN
        check(name, {32'd0, retire_count}, {32'd0, exp_retire});
`else
        check(name, {32'd0, retire_count}, 64'd0);
`endif
    endtask

    // Monitor: the transfer takes effect at the next posedge, so the pop and
    // compare happen on the falling edge before it.
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_xfer", {59'd0, wb_addr}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("xfer rd=%0d data=0x%0h en=%0b", wb_addr, wb_data, wb_en);
                check("wb_addr", {59'd0, wb_addr}, {59'd0, e.rd});
                check("wb_data", wb_data, e.data);
                check("wb_en", {63'd0, wb_en}, {63'd0, e.en});
            end
            exp_retire <= exp_retire + 32'd1;
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_regwrite = 1'b0; in_mem_to_reg = 1'b0;
        in_rd = '0; in_alu_result = '0; in_mem_data = '0; flush = 1'b0; wb_ready = 1'b1;
        cycle(); cycle();
        // Reset state
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_wb_en", {63'd0, wb_en}, 64'd0);
        check("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_retire("rst_retire");
        reset = 1'b0;
        cycle();

        // Single entry, ALU path, one-cycle latency
        send(5'd5, 64'h1234, 64'h0, 1'b0, 1'b1, 1'b0);
        check("lat_wb_valid", {63'd0, wb_valid}, 64'd1);
        check("lat_wb_en", {63'd0, wb_en}, 64'd1);
        cycle();
        check("drain_empty", {63'd0, wb_valid}, 64'd0);

        // Load path, X31 write, regwrite=0
        send(5'd7, 64'h1, 64'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        send(5'd31, 64'h55, 64'h0, 1'b0, 1'b1, 1'b0);
        check("x31_valid", {63'd0, wb_valid}, 64'd1);
        check("x31_en", {63'd0, wb_en}, 64'd0);
        send(5'd3, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_retire("retire_after_4");

        // Back-pressure: A then B fill head and skid
        wb_ready = 1'b0;
        send(5'd1, 64'hA, 64'h0, 1'b0, 1'b1, 1'b0);
        send(5'd2, 64'hB, 64'h0, 1'b0, 1'b1, 1'b0);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_head_addr", {59'd0, wb_addr}, 64'd1);
        cycle();
        check("hold_head_addr", {59'd0, wb_addr}, 64'd1);
        check("hold_head_data", wb_data, 64'hA);
        wb_ready = 1'b1;
        cycle();
        check("after_A_in_ready", {63'd0, in_ready}, 64'd1);
        check("after_A_head", {59'd0, wb_addr}, 64'd2);
        cycle();
        check("after_B_empty", {63'd0, wb_valid}, 64'd0);

        // Streaming: the head is replaced every cycle
        for (int i = 0; i < 4; i++)
            send(5'(10 + i), 64'h100 + 64'(i), 64'h0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Flush in FULL with in_valid=1
        wb_ready = 1'b0;
        send(5'd4, 64'hC, 64'h0, 1'b0, 1'b1, 1'b0);
        send(5'd6, 64'hD, 64'h0, 1'b0, 1'b1, 1'b0);
        send(5'd8, 64'hE, 64'h0, 1'b0, 1'b1, 1'b1);
        check("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_addr_hold", {59'd0, wb_addr}, 64'd4);
        sb.delete();
        // Flush in ONE with a coincident upstream beat, which is discarded
        send(5'd9, 64'hF0, 64'h0, 1'b0, 1'b1, 1'b0);
        send(5'd12, 64'hF1, 64'h0, 1'b0, 1'b1, 1'b1);
        check("flush1_wb_valid", {63'd0, wb_valid}, 64'd0);
        sb.delete();
        wb_ready = 1'b1;
        cycle(); cycle();
        // A coincident downstream transfer still completes
        send(5'd13, 64'h1313, 64'h0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_xfer_empty", {63'd0, wb_valid}, 64'd0);
        check_retire("retire_flush_xfer");

        // Reset asserted mid-transfer loses the in-flight entry
        wb_ready = 1'b0;
        send(5'd14, 64'h1414, 64'h0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        sb.delete();
        exp_retire = 32'd0;
        check("midrst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check_retire("midrst_retire");
        wb_ready = 1'b1;
        send(5'd15, 64'h1515, 64'h0, 1'b0, 1'b1, 1'b0);
        cycle();

`ifdef WB_RETIRE_COUNT_EN
        // Preload the counter next to its wrap point, then make one transfer
        force dut.r_retire_count = 32'hFFFF_FFFF;
        cycle();
        release dut.r_retire_count;
        exp_retire = 32'hFFFF_FFFF;
        check("preload_retire", {32'd0, retire_count}, 64'hFFFF_FFFF);
        send(5'd16, 64'h1616, 64'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("wrap_retire", {32'd0, retire_count}, 64'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        exp_retire = 32'd0;
        check("rst_clr_retire", {32'd0, retire_count}, 64'd0);
`endif

        cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard time limit so that the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
